// File: rtl/draw_engine_if.sv
// Bus bundle between draw_engine and its command FIFO / framebuffer RAM.
// The engine takes the master modport; the FIFO/RAM side takes slave.
interface draw_engine_if #(
  parameter int FB_AW = 8
);
  logic             fifo_empty;
  logic             fifo_err;
  logic [19:0]      fifo_out;
  logic             fifo_read;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_wdata;
  logic             fb_we;
  logic [7:0]       fb_rdata;
  logic             busy;
  logic             done;
  logic             collision;
  logic             err;

  modport master (
    input  fifo_empty, fifo_err, fifo_out, fb_rdata,
    output fifo_read, fb_addr, fb_wdata, fb_we, busy, done, collision, err
  );

  modport slave (
    output fifo_empty, fifo_err, fifo_out, fb_rdata,
    input  fifo_read, fb_addr, fb_wdata, fb_we, busy, done, collision, err
  );
endinterface

// File: rtl/draw_engine.sv
// Chip8 draw engine: pops draw/clear commands and XORs sprite rows into the 64x32 framebuffer.
// Optional macro DRAW_CLIP_EN: drop sprite pixels past column 63 instead of wrapping to byte 0.
module draw_engine #(
  parameter int         FB_AW      = 8,
  parameter logic [7:0] CLEAR_FILL = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  draw_engine_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RD0, WR0, RD1, WR1, CLEAR, DONE
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  x_p0;
  logic [4:0]  y_p0;
  logic [7:0]  spr_p0;
  logic [7:0]  cnt;
  logic        coll;
  logic        collision_r;
  logic        err_r;

  logic [2:0]  xo, col0, col1;
  logic [7:0]  mask0, mask1;
  logic        hit;

  logic             fifo_read_c;
  logic [FB_AW-1:0] addr_c;
  logic [7:0]       wdata_c;
  logic             we_c;

  assign xo    = x_p0[2:0];
  assign col0  = x_p0[5:3];
  assign col1  = col0 + 3'd1;
  assign mask0 = spr_p0 >> xo;
  // Spill of the sprite into the next byte; xo is 1..7 whenever this is used.
  assign mask1 = spr_p0 << (4'd8 - {1'b0, xo});

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      coll        <= 1'b0;
      collision_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.fifo_err)
        err_r <= 1'b1;
      if (state == LOAD)
        coll <= 1'b0;
      else if (state == WR0 || state == WR1)
        coll <= coll | hit;
      if (state == DONE)
        collision_r <= coll;
    end
  end

  // Command capture stage: fifo_out is valid in LOAD, one cycle after the pop
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      x_p0   <= bus.fifo_out[18:13];
      y_p0   <= bus.fifo_out[12:8];
      spr_p0 <= bus.fifo_out[7:0];
      cnt    <= 8'd0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx    = state;
    fifo_read_c = 1'b0;
    addr_c      = '0;
    wdata_c     = 8'h00;
    we_c        = 1'b0;
    hit         = |(bus.fb_rdata & ((state == WR1) ? mask1 : mask0));
    case (state)
      IDLE: begin
        if (!bus.fifo_empty && !rst) begin
          fifo_read_c = 1'b1;
          state_nx    = LOAD;
        end
      end
      LOAD:  state_nx = bus.fifo_out[19] ? CLEAR : RD0;
      RD0: begin
        addr_c   = FB_AW'({y_p0, col0});
        state_nx = WR0;
      end
      WR0: begin
        addr_c  = FB_AW'({y_p0, col0});
        we_c    = 1'b1;
        wdata_c = bus.fb_rdata ^ mask0;
        if (xo == 3'd0)
          state_nx = DONE;
`ifdef DRAW_CLIP_EN
        else if (col0 == 3'd7)
          state_nx = DONE;
`endif
        else
          state_nx = RD1;
      end
      RD1: begin
        addr_c   = FB_AW'({y_p0, col1});
        state_nx = WR1;
      end
      WR1: begin
        addr_c   = FB_AW'({y_p0, col1});
        we_c     = 1'b1;
        wdata_c  = bus.fb_rdata ^ mask1;
        state_nx = DONE;
      end
      CLEAR: begin
        addr_c  = FB_AW'(cnt);
        we_c    = 1'b1;
        wdata_c = CLEAR_FILL;
        if (cnt == 8'hFF)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.fifo_read = fifo_read_c;
  assign bus.fb_addr   = addr_c;
  assign bus.fb_wdata  = wdata_c;
  assign bus.fb_we     = we_c;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.collision = collision_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_draw_engine.sv
// Directed bench for draw_engine: FIFO and 256-byte framebuffer models with hand-computed results.
module tb_draw_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;

  draw_engine_if #(.FB_AW(8)) bus ();

  draw_engine #(.FB_AW(8), .CLEAR_FILL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model: pushed from the stimulus thread, popped on fifo_read with one-cycle data latency
  logic [19:0] cmds [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  logic fifo_err_drv = 1'b0;
  assign bus.fifo_err = fifo_err_drv;

  always @(posedge clk) begin
    if (bus.fifo_read) begin
      bus.fifo_out <= cmds[rd_ptr % 16];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Framebuffer model, synchronous read, prefilled so a clear is visible
  logic [7:0] mem [256] = '{default: 8'hA5};
  always @(posedge clk) begin
    bus.fb_rdata <= mem[bus.fb_addr];
    if (bus.fb_we)
      mem[bus.fb_addr] <= bus.fb_wdata;
  end

  // Event monitor on the falling edge
  int cyc = 0;
  int n_rd = 0, n_done = 0, n_we = 0, n_we_nz = 0, rd_busy = 0, rd_b2b = 0;
  int rd_cyc [64];
  int done_cyc [64];
  logic prev_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.fifo_read) begin
      if (n_rd < 64) rd_cyc[n_rd] <= cyc;
      n_rd <= n_rd + 1;
      if (bus.busy) rd_busy <= rd_busy + 1;
      if (prev_rd) rd_b2b <= rd_b2b + 1;
    end
    prev_rd <= bus.fifo_read;
    if (bus.done) begin
      if (n_done < 64) done_cyc[n_done] <= cyc;
      n_done <= n_done + 1;
    end
    if (bus.fb_we) begin
      n_we <= n_we + 1;
      if (bus.fb_wdata != 8'h00) n_we_nz <= n_we_nz + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] draw_cmd(input int x, input int y, input logic [7:0] b);
    return {1'b0, 6'(x), 5'(y), b};
  endfunction

  task automatic push(input logic [19:0] c);
    cmds[wr_ptr % 16] = c;
    wr_ptr++;
  endtask

  task automatic run_cmd(input string tag, input logic [19:0] c, input int lat);
    int  d0;
    bit  to;
    d0 = n_done;
    to = 1'b1;
    push(c);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (n_done > d0) begin
        to = 1'b0;
        break;
      end
    end
    chk({tag, " timeout"}, 32'(to), 32'd0);
    chk({tag, " latency"}, 32'(done_cyc[(n_done - 1) % 64] - rd_cyc[(n_rd - 1) % 64]), 32'(lat));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ctrl"}, {26'd0, bus.fifo_read, bus.fb_we, bus.busy, bus.done, bus.collision, bus.err}, 32'd0);
    chk({tag, " addr"}, {24'd0, bus.fb_addr}, 32'd0);
    chk({tag, " wdata"}, {24'd0, bus.fb_wdata}, 32'd0);
  endtask

  initial begin
    int d0, we0, nz0, rd0, nz_bytes;
    bit to;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Clear: 256 writes of 0x00, done at t+258
    we0 = n_we; nz0 = n_we_nz;
    run_cmd("clear", 20'h80000, 258);
    chk("clear writes", 32'(n_we - we0), 32'd256);
    chk("clear nonzero writes", 32'(n_we_nz - nz0), 32'd0);
    nz_bytes = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 8'h00) nz_bytes++;
    chk("clear fb nonzero bytes", 32'(nz_bytes), 32'd0);
    chk("clear collision", 32'(bus.collision), 32'd0);

    // Aligned draw, then the same draw again to erase it with collision
    run_cmd("draw0", draw_cmd(0, 0, 8'hF0), 4);
    chk("draw0 fb0", 32'(mem[0]), 32'hF0);
    chk("draw0 collision", 32'(bus.collision), 32'd0);
    run_cmd("redraw0", draw_cmd(0, 0, 8'hF0), 4);
    chk("redraw0 fb0", 32'(mem[0]), 32'h00);
    chk("redraw0 collision", 32'(bus.collision), 32'd1);

    // Unaligned draw spanning two bytes
    run_cmd("draw3", draw_cmd(3, 1, 8'hFF), 6);
    chk("draw3 fb8", 32'(mem[8]), 32'h1F);
    chk("draw3 fb9", 32'(mem[9]), 32'hE0);
    chk("draw3 collision", 32'(bus.collision), 32'd0);

    // Right edge: wrap to byte 0 of the row, or clip
`ifdef DRAW_CLIP_EN
    run_cmd("draw60", draw_cmd(60, 2, 8'hFF), 4);
    chk("draw60 fb16", 32'(mem[16]), 32'h00);
`else
    run_cmd("draw60", draw_cmd(60, 2, 8'hFF), 6);
    chk("draw60 fb16", 32'(mem[16]), 32'hF0);
`endif
    chk("draw60 fb23", 32'(mem[23]), 32'h0F);
    chk("draw60 collision", 32'(bus.collision), 32'd0);

    // Four commands queued at once
    d0 = n_done; rd0 = n_rd;
    push(draw_cmd(0, 10, 8'hAA));
    push(draw_cmd(0, 10, 8'h0F));
    push(draw_cmd(16, 10, 8'h3C));
    push(draw_cmd(4, 11, 8'hFF));
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (n_done >= d0 + 4) begin
        to = 1'b0;
        break;
      end
    end
    repeat (5) @(posedge clk);
    #1;
    chk("batch timeout", 32'(to), 32'd0);
    chk("batch reads", 32'(n_rd - rd0), 32'd4);
    chk("batch dones", 32'(n_done - d0), 32'd4);
    for (int i = 0; i < 3; i++)
      chk($sformatf("batch gap%0d", i), 32'(rd_cyc[rd0 + i + 1] - done_cyc[d0 + i]), 32'd1);
    chk("read while busy", 32'(rd_busy), 32'd0);
    chk("read back-to-back", 32'(rd_b2b), 32'd0);
    chk("batch fb80", 32'(mem[80]), 32'hA5);
    chk("batch fb82", 32'(mem[82]), 32'h3C);
    chk("batch fb88", 32'(mem[88]), 32'h0F);
    chk("batch fb89", 32'(mem[89]), 32'hF0);
    chk("batch collision", 32'(bus.collision), 32'd0);

    run_cmd("draw200", draw_cmd(0, 25, 8'h77), 4);
    chk("draw200 fb200", 32'(mem[200]), 32'h77);

    // Reset during cycle 100 of a clear
    d0 = n_done;
    push(20'h80000);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fb_we) begin
        to = 1'b0;
        break;
      end
    end
    chk("abort clear start", 32'(to), 32'd0);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("abort reset");
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("abort no done", 32'(n_done - d0), 32'd0);
    chk("abort fb80 cleared", 32'(mem[80]), 32'h00);
    chk("abort fb200 kept", 32'(mem[200]), 32'h77);

    // Sticky error flag
    chk("err before", 32'(bus.err), 32'd0);
    fifo_err_drv = 1'b1;
    @(posedge clk); #1;
    fifo_err_drv = 1'b0;
    chk("err set", 32'(bus.err), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("err held", 32'(bus.err), 32'd1);
    run_cmd("draw240", draw_cmd(0, 30, 8'h03), 4);
    chk("draw240 fb240", 32'(mem[240]), 32'h03);
    chk("err after draw", 32'(bus.err), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("err reset", 32'(bus.err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/draw_engine.md
Name: draw_engine

Overview:
- Consumer stage directly downstream of the 20-bit command FIFO in the Chip8 display path.
- Pops one draw command at a time and applies it to the 64x32 monochrome framebuffer using read-modify-write. A draw XORs one 8-pixel sprite row into the framebuffer; a clear fills the framebuffer.
- Reports collision (Chip8 VF semantics) and completion per command to the CPU core.

Parameters:
- FB_AW, 8, framebuffer byte-address width (32 rows x 8 bytes = 256 bytes; fixed by command format).
- CLEAR_FILL, 8'h00, byte written to every location by a clear command.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- fifo_empty  input  1  FIFO empty flag
- fifo_err  input  1  FIFO error flag
- fifo_out  input  20  FIFO head data; valid the cycle after fifo_read
- fifo_read  output  1  one-cycle pop strobe to FIFO
- fb_addr  output  FB_AW  framebuffer byte address, computed as y*8 + byte column
- fb_wdata  output  8  framebuffer write data; bit7 = leftmost pixel
- fb_we  output  1  framebuffer write enable
- fb_rdata  input  8  framebuffer read data; 1-cycle synchronous read latency
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when a command completes
- collision  output  1  collision result of the last completed command
- err  output  1  sticky error flag

Behaviour:
- Command format:
  - bit19 = clr.
  - [18:13] = x (0-63); [12:8] = y (0-31); [7:0] = sprite row byte.
  - When clr=1, bits [18:0] are ignored.
- Reset values: fifo_read=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0, collision=0, err=0; state=IDLE.
- Reset mid-command: return to IDLE immediately. Writes already issued stay in the framebuffer. Remaining writes are dropped, and there is no done pulse.
- States:
  - IDLE: if !fifo_empty, assert fifo_read for 1 cycle → LOAD. fifo_empty is ignored in all other states. fifo_read is never asserted twice back-to-back.
  - LOAD: capture fifo_out. If clr → CLEAR; else → RD0.
  - RD0: fb_addr = {y, x[5:3]}.
  - WR0: fb_we=1, fb_wdata = fb_rdata ^ (byte >> x[2:0]). Accumulate coll |= |(fb_rdata & (byte >> x[2:0])). If x[2:0]==0 → DONE; else → RD1.
  - RD1: fb_addr = {y, x[5:3]+1}. The byte column wraps modulo 8 within the same row; see Optional Feature.
  - WR1: fb_we=1, fb_wdata = fb_rdata ^ (byte << (8-x[2:0])), truncated to 8 bits. Accumulate coll the same way → DONE.
  - CLEAR: 256 consecutive cycles. fb_we=1, fb_addr = 0..255 incrementing, fb_wdata = CLEAR_FILL. After addr 255 → DONE. coll=0.
  - DONE: done=1 for one cycle, collision<=coll, then → IDLE.
- Latency, counted from the fifo_read cycle t:
  - Aligned draw: done at t+4.
  - Unaligned draw: done at t+6.
  - Clear: done at t+258.
- Back-to-back commands: the next fifo_read can occur at done+1.
- collision holds its value until the next done.
- y wraps naturally (5 bits). A y*8 + column address always lies in 0-255.
- fifo_err: when high on any cycle, err<=1. err stays set until rst. Command processing is otherwise unaffected.
- fb_we is high only in WR0, WR1 and CLEAR.

Optional Feature:
- Macro: DRAW_CLIP_EN.
- Defined: when x[5:3]==7 and x[2:0]!=0, skip RD1/WR1 and go WR0 → DONE. Pixels beyond column 63 are discarded, and done occurs at t+4.
- Undefined (default): the second byte wraps to column byte 0 of the same row, as stated in RD1.

Test Plan:
- Clear, then draw x=0,y=0,byte=0xF0 → 256 clear writes of 0x00 then done. Draw writes fb[0]=0xF0 and done at t+4 with collision=0.
- Repeat the same draw → fb[0]=0x00, collision=1, done at t+4.
- Draw x=3,y=1,byte=0xFF on cleared fb → fb[8]=0x1F, fb[9]=0xE0, collision=0, done at t+6.
- Draw x=60,y=2,byte=0xFF on cleared fb:
  - Without DRAW_CLIP_EN → fb[23]=0x0F, fb[16]=0xF0, done at t+6.
  - With DRAW_CLIP_EN → only fb[23]=0x0F, fb[16] untouched, done at t+4.
- Enqueue 4 draws back-to-back → exactly 4 fifo_read pulses, each one cycle after the prior done. No fifo_read while busy; 4 done pulses in total.
- Assert rst during cycle 100 of a clear → outputs reach reset values next cycle, no done pulse. Pulse fifo_err once afterwards → err=1 and stays high until the next rst.
